// File: rtl/multi_del_meas.sv
// Multi-channel delay measurement: pulses selected DAC channels, times ADC echoes against a magnitude threshold over N shots.
// Latency: all outputs registered; an echo D cycles after the pulse appears on dac_data records latency D.
// Backpressure: none; ADC samples are qualified only by adc_valid, DAC outputs are always presented with dac_valid.
module multi_del_meas #(
    parameter int NUM_BITS = 16,
    parameter int NUM_DAC  = 3,
    parameter int NUM_ADC  = 2,
    parameter int CNT_W    = 16,
    parameter int SHOT_W   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [NUM_DAC-1:0]          dac_mask,
    input  logic [NUM_BITS-1:0]         pulse_val,
    input  logic [NUM_BITS-1:0]         thresh,
    input  logic [CNT_W-1:0]            timeout,
    input  logic [CNT_W-1:0]            settle_cycles,
    input  logic [SHOT_W-1:0]           num_shots,
    input  logic [NUM_ADC*NUM_BITS-1:0] adc_data,
    input  logic [NUM_ADC-1:0]          adc_valid,
    output logic                        adc_run,
    output logic [NUM_DAC*NUM_BITS-1:0] dac_data,
    output logic [NUM_DAC-1:0]          dac_valid,
    output logic [NUM_ADC*CNT_W-1:0]    res_min,
    output logic [NUM_ADC*CNT_W-1:0]    res_max,
    output logic [NUM_ADC-1:0]          res_to,
    output logic                        settle_err,
    output logic                        done,
    output logic                        busy,
    output logic [2:0]                  state_out
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PULSE   = 3'd1,
        S_MEASURE = 3'd2,
        S_SETTLE  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [SHOT_W-1:0] SHOT_ONE = SHOT_W'(1);

    state_t state, state_nxt;

    // configuration captured when a run starts
    logic [NUM_DAC-1:0]  cfg_mask;
    logic [NUM_BITS-1:0] cfg_pulse;
    logic [NUM_BITS-1:0] cfg_thresh;
    logic [CNT_W-1:0]    cfg_timeout;
    logic [CNT_W-1:0]    cfg_settle;
    logic [SHOT_W-1:0]   cfg_shots;

    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    quiet_cnt;
    logic [SHOT_W-1:0]   shot_cnt;
    logic [NUM_ADC-1:0]  hit_flag;
    logic [NUM_ADC-1:0]  ever_hit;
    logic [CNT_W-1:0]    min_r [NUM_ADC];
    logic [CNT_W-1:0]    max_r [NUM_ADC];

    logic [NUM_ADC-1:0]          over;
    logic [NUM_ADC-1:0]          hit_now;
    logic                        all_hit;
    logic                        quiet;
    logic [CNT_W-1:0]            to_eff;
    logic                        at_to;
    logic [CNT_W-1:0]            cnt_inc;
    logic [CNT_W-1:0]            quiet_nxt;
    logic                        settled;
    logic [SHOT_W-1:0]           shots_eff;
    logic                        last_shot;
    logic                        run_nxt;
    logic [NUM_DAC-1:0]          src_mask;
    logic [NUM_BITS-1:0]         src_val;
    logic [NUM_DAC*NUM_BITS-1:0] pulse_dat;
    logic [NUM_ADC*CNT_W-1:0]    rep_min;
    logic [NUM_ADC*CNT_W-1:0]    rep_max;

    // Absolute value of a two's complement sample; the most-negative code saturates to max positive.
    function automatic logic [NUM_BITS-1:0] mag_of(input logic [NUM_BITS-1:0] s);
        if (!s[NUM_BITS-1])
            mag_of = s;
        else if (s[NUM_BITS-2:0] == '0)
            mag_of = {1'b0, {(NUM_BITS-1){1'b1}}};
        else
            mag_of = (~s) + 1'b1;
    endfunction

    assign state_out = state;
    assign hit_now   = over & ~hit_flag;
    assign all_hit   = &(hit_flag | over);
    assign quiet     = ~|over;
    assign to_eff    = (cfg_timeout == '0) ? CNT_ONE : cfg_timeout;
    assign at_to     = (cnt >= to_eff);
    assign cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    assign quiet_nxt = !quiet ? '0 : ((quiet_cnt == CNT_MAX) ? quiet_cnt : quiet_cnt + 1'b1);
    assign settled   = (quiet_nxt >= cfg_settle);
    assign shots_eff = (cfg_shots == '0) ? SHOT_ONE : cfg_shots;
    assign last_shot = ((shot_cnt + 1'b1) == shots_eff);
    assign run_nxt   = (state_nxt == S_PULSE) || (state_nxt == S_MEASURE) || (state_nxt == S_SETTLE);
    // the first pulse leaves IDLE on the same edge the config is latched, so take it from the inputs
    assign src_mask  = (state == S_IDLE) ? dac_mask  : cfg_mask;
    assign src_val   = (state == S_IDLE) ? pulse_val : cfg_pulse;

    // Per-channel threshold comparison of the current ADC sample.
    always_comb begin
        over = '0;
        for (int i = 0; i < NUM_ADC; i++)
            over[i] = adc_valid[i] && (mag_of(adc_data[i*NUM_BITS +: NUM_BITS]) > cfg_thresh);
    end

    // Pulse word: amplitude on masked channels, zero elsewhere.
    always_comb begin
        pulse_dat = '0;
        for (int i = 0; i < NUM_DAC; i++)
            if (src_mask[i])
                pulse_dat[i*NUM_BITS +: NUM_BITS] = src_val;
    end

    // Reported results: channels that never hit show all-ones for both min and max.
    always_comb begin
        rep_min = '0;
        rep_max = '0;
        for (int i = 0; i < NUM_ADC; i++) begin
            rep_min[i*CNT_W +: CNT_W] = ever_hit[i] ? min_r[i] : CNT_MAX;
            rep_max[i*CNT_W +: CNT_W] = ever_hit[i] ? max_r[i] : CNT_MAX;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start) state_nxt = S_PULSE;
            S_PULSE:   state_nxt = S_MEASURE;
            S_MEASURE: if (all_hit || at_to) state_nxt = S_SETTLE;
            S_SETTLE: begin
                if (settled)
                    state_nxt = last_shot ? S_DONE : S_PULSE;
                else if (at_to)
                    state_nxt = S_DONE;
            end
            S_DONE:    if (!start) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Datapath: counters, hit tracking, min/max accumulation and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_mask    <= '0;
            cfg_pulse   <= '0;
            cfg_thresh  <= '0;
            cfg_timeout <= '0;
            cfg_settle  <= '0;
            cfg_shots   <= '0;
            cnt         <= '0;
            quiet_cnt   <= '0;
            shot_cnt    <= '0;
            hit_flag    <= '0;
            ever_hit    <= '0;
            for (int i = 0; i < NUM_ADC; i++) begin
                min_r[i] <= CNT_MAX;
                max_r[i] <= '0;
            end
            adc_run     <= 1'b0;
            busy        <= 1'b0;
            dac_valid   <= '0;
            dac_data    <= '0;
            res_min     <= '0;
            res_max     <= '0;
            res_to      <= '0;
            settle_err  <= 1'b0;
            done        <= 1'b0;
        end else begin
            adc_run   <= run_nxt;
            busy      <= run_nxt;
            dac_valid <= run_nxt ? '1 : '0;
            dac_data  <= (state_nxt == S_PULSE) ? pulse_dat : '0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        cfg_mask    <= dac_mask;
                        cfg_pulse   <= pulse_val;
                        cfg_thresh  <= thresh;
                        cfg_timeout <= timeout;
                        cfg_settle  <= settle_cycles;
                        cfg_shots   <= num_shots;
                        shot_cnt    <= '0;
                        ever_hit    <= '0;
                        for (int i = 0; i < NUM_ADC; i++) begin
                            min_r[i] <= CNT_MAX;
                            max_r[i] <= '0;
                        end
                        res_min     <= '0;
                        res_max     <= '0;
                        res_to      <= '0;
                        settle_err  <= 1'b0;
                        done        <= 1'b0;
                    end
                end
                S_PULSE: begin
                    cnt      <= CNT_ONE;
                    hit_flag <= '0;
                end
                S_MEASURE: begin
                    cnt <= cnt_inc;
                    for (int i = 0; i < NUM_ADC; i++) begin
                        if (hit_now[i]) begin
                            hit_flag[i] <= 1'b1;
                            ever_hit[i] <= 1'b1;
                            if (cnt < min_r[i]) min_r[i] <= cnt;
                            if (cnt > max_r[i]) max_r[i] <= cnt;
                        end
                    end
                    if (all_hit || at_to) begin
                        res_to    <= res_to | ~(hit_flag | over);
                        cnt       <= CNT_ONE;
                        quiet_cnt <= '0;
                    end
                end
                S_SETTLE: begin
                    cnt       <= cnt_inc;
                    quiet_cnt <= quiet_nxt;
                    if (settled)
                        shot_cnt <= shot_cnt + 1'b1;
                    else if (at_to)
                        settle_err <= 1'b1;
                    if (state_nxt == S_DONE) begin
                        done    <= 1'b1;
                        res_min <= rep_min;
                        res_max <= rep_max;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_del_meas.sv
// Directed bench for multi_del_meas with a delayed-loopback ADC model.
// Latency: checks echo-delay latencies, shot counts, timeouts and settle errors.
// Backpressure: none; ADC valid held high, samples driven on the falling edge.
module tb_multi_del_meas;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  dac_mask = '0;
    logic [15:0] pulse_val = '0;
    logic [15:0] thresh = '0;
    logic [15:0] timeout = '0;
    logic [15:0] settle_cycles = '0;
    logic [3:0]  num_shots = '0;
    logic [31:0] adc_data = '0;
    logic [1:0]  adc_valid = '0;
    logic        adc_run;
    logic [47:0] dac_data;
    logic [2:0]  dac_valid;
    logic [31:0] res_min;
    logic [31:0] res_max;
    logic [1:0]  res_to;
    logic        settle_err;
    logic        done;
    logic        busy;
    logic [2:0]  state_out;

    multi_del_meas dut (
        .clk(clk), .rst(rst), .start(start), .dac_mask(dac_mask), .pulse_val(pulse_val),
        .thresh(thresh), .timeout(timeout), .settle_cycles(settle_cycles), .num_shots(num_shots),
        .adc_data(adc_data), .adc_valid(adc_valid), .adc_run(adc_run), .dac_data(dac_data),
        .dac_valid(dac_valid), .res_min(res_min), .res_max(res_max), .res_to(res_to),
        .settle_err(settle_err), .done(done), .busy(busy), .state_out(state_out)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // loopback model state
    int          k = 1000;
    int          sidx = 0;
    int          cur = 0;
    int          pulse_cnt = 0;
    int          meas_cnt = 0;
    int          dly0 [4] = '{5, 5, 5, 5};
    int          dly1 = 9;
    bit          ch1_on = 1'b1;
    bit          hold = 1'b0;
    logic [15:0] echo0 = 16'd1000;
    logic [15:0] echo1 = 16'd1000;
    logic [47:0] pulse_dat_seen = '0;
    logic [2:0]  pulse_vld_seen = '0;

    // Echo each channel D cycles after the pulse cycle; optionally hold it afterwards.
    always @(negedge clk) begin
        int d0;
        if (state_out == 3'd0) sidx = 0;
        if (state_out == 3'd1) begin
            k = 0;
            cur = sidx;
            sidx++;
            pulse_cnt++;
            pulse_dat_seen = dac_data;
            pulse_vld_seen = dac_valid;
        end else if (k < 1000) begin
            k++;
        end
        if (state_out == 3'd2) meas_cnt++;
        d0 = dly0[cur & 3];
        adc_data[15:0]  = ((hold && k >= d0) || k == d0) ? echo0 : 16'h0000;
        adc_data[31:16] = (ch1_on && ((hold && k >= dly1) || k == dly1)) ? echo1 : 16'h0000;
        adc_valid = 2'b11;
    end

    task automatic set_cfg(input logic [2:0] m, input logic [15:0] pv, input logic [15:0] th,
                           input logic [15:0] to, input logic [15:0] st, input logic [3:0] ns);
        dac_mask = m;
        pulse_val = pv;
        thresh = th;
        timeout = to;
        settle_cycles = st;
        num_shots = ns;
    endtask

    task automatic do_run(input int budget);
        int n;
        n = 0;
        start = 1'b1;
        @(negedge clk);
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("run_done", {63'd0, done}, 64'd1);
    endtask

    task automatic end_run();
        start = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int p0;
        int m0;
        int n;

        set_cfg(3'b101, 16'd1000, 16'd100, 16'd50, 16'd0, 4'd1);
        repeat (3) @(negedge clk);
        chk("rst_state", state_out, 3'd0);
        chk("rst_res", {res_min, res_max}, 64'd0);
        chk("rst_outs", {adc_run, dac_data, dac_valid, res_to, settle_err, done, busy}, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // 1: basic loopback, delays 5 and 9
        p0 = pulse_cnt;
        m0 = meas_cnt;
        do_run(500);
        chk("t1_dac_pulse", pulse_dat_seen, 48'h03E8_0000_03E8);
        chk("t1_dac_vld", pulse_vld_seen, 3'b111);
        chk("t1_min", res_min, {16'd9, 16'd5});
        chk("t1_max", res_max, {16'd9, 16'd5});
        chk("t1_to_err", {res_to, settle_err}, 3'b000);
        chk("t1_flags", {done, busy, adc_run, dac_valid}, 6'b100000);
        chk("t1_meas_cycles", meas_cnt - m0, 9);
        chk("t1_pulses", pulse_cnt - p0, 1);
        end_run();

        // 2: negative pulse and echo
        set_cfg(3'b111, 16'hFC18, 16'd100, 16'd50, 16'd0, 4'd1);
        echo0 = 16'hFC18;
        echo1 = 16'hFC18;
        do_run(500);
        chk("t2_dac_pulse", pulse_dat_seen, 48'hFC18_FC18_FC18);
        chk("t2_min", res_min, {16'd9, 16'd5});
        chk("t2_max", res_max, {16'd9, 16'd5});
        end_run();

        // 2b: most-negative sample saturates to 0x7FFF, above 0x7FFE
        set_cfg(3'b001, 16'hFC18, 16'h7FFE, 16'd50, 16'd0, 4'd1);
        echo0 = 16'h8000;
        echo1 = 16'h8000;
        do_run(500);
        chk("t2b_min", res_min, {16'd9, 16'd5});
        chk("t2b_to", res_to, 2'b00);
        end_run();

        // 2c: saturated 0x7FFF is not above 0x7FFF
        set_cfg(3'b001, 16'hFC18, 16'h7FFF, 16'd20, 16'd0, 4'd1);
        do_run(500);
        chk("t2c_to", res_to, 2'b11);
        chk("t2c_min", res_min, 32'hFFFF_FFFF);
        chk("t2c_max", res_max, 32'hFFFF_FFFF);
        end_run();

        // 2d: threshold is strict: 101 hits, 100 does not
        set_cfg(3'b001, 16'd1000, 16'd100, 16'd20, 16'd0, 4'd1);
        echo0 = 16'd101;
        echo1 = 16'd100;
        do_run(500);
        chk("t2d_to", res_to, 2'b10);
        chk("t2d_min", res_min, {16'hFFFF, 16'd5});
        end_run();

        // 3: ch1 disconnected, timeout 20
        echo0 = 16'd1000;
        echo1 = 16'd1000;
        ch1_on = 1'b0;
        set_cfg(3'b001, 16'd1000, 16'd100, 16'd20, 16'd0, 4'd1);
        m0 = meas_cnt;
        do_run(500);
        chk("t3_min", res_min, {16'hFFFF, 16'd5});
        chk("t3_max", res_max, {16'hFFFF, 16'd5});
        chk("t3_to", res_to, 2'b10);
        chk("t3_meas_cycles", meas_cnt - m0, 20);
        end_run();

        // 4: four shots with varying ch0 delay, then num_shots=0
        ch1_on = 1'b1;
        dly0 = '{5, 6, 7, 5};
        set_cfg(3'b001, 16'd1000, 16'd100, 16'd50, 16'd3, 4'd4);
        p0 = pulse_cnt;
        do_run(1000);
        chk("t4_min", res_min, {16'd9, 16'd5});
        chk("t4_max", res_max, {16'd9, 16'd7});
        chk("t4_pulses", pulse_cnt - p0, 4);
        chk("t4_err", {res_to, settle_err}, 3'b000);
        end_run();
        set_cfg(3'b001, 16'd1000, 16'd100, 16'd50, 16'd3, 4'd0);
        p0 = pulse_cnt;
        do_run(1000);
        chk("t4_zero_shots", pulse_cnt - p0, 1);
        chk("t4_zero_max", res_max, {16'd9, 16'd5});
        end_run();

        // 5: echo held high, settle never goes quiet
        dly0 = '{5, 5, 5, 5};
        hold = 1'b1;
        set_cfg(3'b001, 16'd1000, 16'd100, 16'd30, 16'd3, 4'd2);
        p0 = pulse_cnt;
        do_run(1000);
        chk("t5_settle_err", settle_err, 1'b1);
        chk("t5_pulses", pulse_cnt - p0, 1);
        chk("t5_min", res_min, {16'd9, 16'd5});
        end_run();
        hold = 1'b0;
        repeat (2) @(negedge clk);

        // 6: reset mid-MEASURE
        set_cfg(3'b101, 16'd1000, 16'd100, 16'd50, 16'd0, 4'd1);
        start = 1'b1;
        n = 0;
        while (state_out !== 3'd2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t6_in_measure", state_out, 3'd2);
        rst = 1'b0;
        start = 1'b0;
        #1;
        chk("t6_async_outs", {adc_run, dac_data, dac_valid, res_to, settle_err, done, busy}, 64'd0);
        chk("t6_async_state", state_out, 3'd0);
        @(posedge clk);
        #1;
        chk("t6_edge_outs", {adc_run, dac_valid, res_to, settle_err, done, busy, state_out}, 64'd0);
        chk("t6_edge_res", {res_min, res_max}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 6b: start held high through DONE never retriggers
        p0 = pulse_cnt;
        do_run(500);
        repeat (30) @(negedge clk);
        chk("t6b_held_pulses", pulse_cnt - p0, 1);
        chk("t6b_held_state", state_out, 3'd4);
        chk("t6b_held_done", done, 1'b1);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6b_idle", state_out, 3'd0);
        chk("t6b_no_rerun", pulse_cnt - p0, 1);
        p0 = pulse_cnt;
        do_run(500);
        chk("t6b_rerun", pulse_cnt - p0, 1);
        chk("t6b_rerun_min", res_min, {16'd9, 16'd5});
        end_run();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/multi_del_meas.md
Name: multi_del_meas

Overview:
- Parametrised successor to the single-shot alpha/beta-gamma delay measurement path of the experiment FSM.
- Pulses any subset of NUM_DAC modulator channels, then times the arrival on each of NUM_ADC detector channels against a magnitude threshold.
- Repeats for a programmable number of shots and reports per-channel min/max latency and timeout flags.
- Sits between the CPU register bank and the DAC/ADC drivers; it is muxed with the experiment FSM outputs.

Parameters:
NUM_BITS, 16, sample width, two's complement
NUM_DAC, 3, DAC channels driven
NUM_ADC, 2, ADC channels timed
CNT_W, 16, latency/timeout counter width
SHOT_W, 4, shot-count field width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
start  in  1  level trigger, sampled in IDLE
dac_mask  in  NUM_DAC  channels receiving the pulse
pulse_val  in  NUM_BITS  pulse amplitude
thresh  in  NUM_BITS  unsigned magnitude threshold
timeout  in  CNT_W  max MEASURE/SETTLE cycles per shot
settle_cycles  in  CNT_W  consecutive quiet cycles required between shots
num_shots  in  SHOT_W  shot count; 0 is treated as 1
adc_data  in  NUM_ADC*NUM_BITS  flat, ch0 in LSBs
adc_valid  in  NUM_ADC  per-channel sample valid
adc_run  out  1  high from PULSE through SETTLE
dac_data  out  NUM_DAC*NUM_BITS  flat
dac_valid  out  NUM_DAC  per-channel valid
res_min  out  NUM_ADC*CNT_W  min latency over non-timed-out shots
res_max  out  NUM_ADC*CNT_W  max latency
res_to  out  NUM_ADC  sticky: channel timed out in at least one shot
settle_err  out  1  settle phase exceeded timeout
done  out  1  results valid
busy  out  1  state != IDLE and != DONE
state_out  out  3  encoded state

Behaviour:
- Reset: all outputs 0. res_min = all-ones, res_max = 0 internally; both are reported per the rules below. FSM -> IDLE. Reset mid-operation aborts immediately; nothing is retained.
- States: IDLE=0, PULSE=1, MEASURE=2, SETTLE=3, DONE=4. All outputs are registered.
- IDLE: start=1 -> PULSE. Latch all config inputs. Clear res_*, settle_err, done; shot counter = 0.
- PULSE (1 cycle):
  - dac_valid = all ones.
  - dac_data = pulse_val on channels set in dac_mask, 0 elsewhere.
  - Latency counter = 1, per-channel hit flags cleared. -> MEASURE.
- MEASURE:
  - dac_data = 0 with valid held at 1 to bias the modulators back to zero.
  - Channel i hits when adc_valid[i] is high and mag(i) > thresh. mag = |adc|; the most-negative value saturates to max positive.
  - On the first hit, record latency = counter; that channel's later hits in the same shot are ignored.
  - Counter increments every cycle.
  - Exit -> SETTLE when all channels have hit or counter == timeout. A hit on the same cycle as the timeout counts as a hit. Un-hit channels set res_to[i].
- Per-shot update:
  - For hit channels: res_min = min(res_min, lat), res_max = max(res_max, lat).
  - Timed-out shots do not update min/max.
- SETTLE:
  - quiet = every channel either has adc_valid low or mag <= thresh.
  - Count consecutive quiet cycles; a non-quiet cycle resets the count.
  - Done when count >= settle_cycles; settle_cycles = 0 passes on the first cycle.
  - If counter reaches timeout first: settle_err = 1 -> DONE, and remaining shots are abandoned.
  - On success: shot++. If shot == effective shots -> DONE, else -> PULSE.
- DONE:
  - done = 1, adc_run = 0, dac_valid = 0.
  - A channel that never hit reports res_min = res_max = all ones.
  - Leave for IDLE only when start = 0. start held high never retriggers.
- Latency reference: the pulse appears on dac_data in cycle T. An echo presented to adc_data D cycles later (cycle T+D, D >= 1) records latency D.
- Counters saturate and never wrap; timeout = 0 behaves as timeout = 1.

Test Plan:
1. Loopback ch0 delay 5, ch1 delay 9, pulse_val=1000, thresh=100, timeout=50, num_shots=1 -> res_min/res_max = {5,9}, res_to=0, done=1, busy=0.
2. Same as 1 with pulse_val=-1000, then an ADC sample of 0x8000 -> identical latencies; 0x8000 is detected as a hit (saturated magnitude).
3. ch1 disconnected, timeout=20 -> ch0 = 5, ch1 res_min = res_max = 0xFFFF, res_to = 2'b10, exactly 20 MEASURE cycles.
4. num_shots=4, ch0 delays 5,6,7,5, settle_cycles=3 -> res_min=5, res_max=7, four PULSE cycles observed; num_shots=0 yields one PULSE.
5. ADC held above thresh after the echo, timeout=30 -> settle_err=1, done after the first shot, no second PULSE.
6. Assert rst low mid-MEASURE -> all outputs 0 and IDLE the next edge. Then hold start high through DONE -> no rerun until start drops and rises again.
